// File: rtl/circuito_exp6.sv
// rtl/circuito_exp6.sv - memory game: replay the ROM sequence, one round longer each time
// Control FSM plus address/limit counters, play register, button edge detector and timeout.
module circuito_exp6 (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic [3:0] leds,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_sequencia,
  output logic       db_igual,
  output logic       db_igualjogada,
  output logic       db_igualseq,
  output logic       db_fimseq,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada,
  output logic       db_timeout
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_GANHOU     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_PERDEU     = 4'hE
  } state_t;

  localparam logic [12:0] TIMEOUT_LAST = 13'd4999;

  state_t      state;
  state_t      nxt;
  logic [3:0]  endereco;
  logic [3:0]  limite;
  logic [3:0]  jogada;
  logic [12:0] tmr;
  logic        botao_ant;
  logic        tem_jogada;
  logic        jogada_feita;
  logic        timeout;
  logic        igual;
  logic [3:0]  dado_rom;

  function automatic logic [3:0] rom(input logic [3:0] a);
    case (a)
      4'h0: rom = 4'b0001;  4'h1: rom = 4'b0010;  4'h2: rom = 4'b0100;  4'h3: rom = 4'b1000;
      4'h4: rom = 4'b0100;  4'h5: rom = 4'b0010;  4'h6: rom = 4'b0001;  4'h7: rom = 4'b0001;
      4'h8: rom = 4'b0010;  4'h9: rom = 4'b0010;  4'hA: rom = 4'b0100;  4'hB: rom = 4'b0100;
      4'hC: rom = 4'b1000;  4'hD: rom = 4'b1000;  4'hE: rom = 4'b0001;  default: rom = 4'b0100;
    endcase
  endfunction

  // active-low segments, bit0 = a ... bit6 = g
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;  4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;  4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;  4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;  4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tem_jogada   = |botoes;
  assign jogada_feita = tem_jogada & ~botao_ant;
  assign timeout      = (tmr == TIMEOUT_LAST);
  assign dado_rom     = rom(endereco);
  assign igual        = (jogada == dado_rom);

  always_comb begin
    nxt = state;
    case (state)
      INICIAL:        if (jogar) nxt = PREPARACAO;
      PREPARACAO:     nxt = INICIA_RODADA;
      INICIA_RODADA:  nxt = ESPERA_JOGADA;
      // a press on the very cycle the timer expires still counts as a play
      ESPERA_JOGADA:  if (jogada_feita) nxt = REGISTRA;
                      else if (timeout) nxt = FIM_TIMEOUT;
      REGISTRA:       nxt = COMPARACAO;
      COMPARACAO:     if (!igual) nxt = FIM_PERDEU;
                      else if (endereco < limite) nxt = PROXIMA_JOGADA;
                      else if (limite != 4'hF) nxt = PROXIMA_RODADA;
                      else nxt = FIM_GANHOU;
      PROXIMA_JOGADA: nxt = ESPERA_JOGADA;
      PROXIMA_RODADA: nxt = INICIA_RODADA;
      FIM_GANHOU, FIM_TIMEOUT, FIM_PERDEU:
                      if (jogar) nxt = PREPARACAO;
      default:        nxt = INICIAL;
    endcase
  end

  // outputs are registered from the next state so they line up with db_estado
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= INICIAL;
      ganhou     <= 1'b0;
      perdeu     <= 1'b0;
      pronto     <= 1'b0;
      db_timeout <= 1'b0;
    end else begin
      state      <= nxt;
      ganhou     <= (nxt == FIM_GANHOU);
      perdeu     <= (nxt == FIM_PERDEU) || (nxt == FIM_TIMEOUT);
      pronto     <= (nxt == FIM_GANHOU) || (nxt == FIM_PERDEU) || (nxt == FIM_TIMEOUT);
      db_timeout <= (nxt == FIM_TIMEOUT);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco  <= 4'h0;
      limite    <= 4'h0;
      jogada    <= 4'h0;
      tmr       <= 13'd0;
      botao_ant <= 1'b0;
    end else begin
      botao_ant <= tem_jogada;
      tmr       <= (state == ESPERA_JOGADA) ? tmr + 13'd1 : 13'd0;
      if (state == PREPARACAO || state == INICIA_RODADA)
        endereco <= 4'h0;
      else if (state == PROXIMA_JOGADA)
        endereco <= endereco + 4'h1;
      if (state == PREPARACAO)
        limite <= 4'h0;
      else if (state == PROXIMA_RODADA)
        limite <= limite + 4'h1;
      if (state == PREPARACAO)
        jogada <= 4'h0;
      else if (state == REGISTRA)
        jogada <= botoes;
    end
  end

  assign leds           = jogada;
  assign db_contagem    = hex7(endereco);
  assign db_memoria     = hex7(dado_rom);
  assign db_estado      = hex7(state);
  assign db_jogadafeita = hex7(jogada);
  assign db_sequencia   = hex7(limite);
  assign db_igual       = igual;
  assign db_igualjogada = igual;
  assign db_igualseq    = (endereco == limite);
  assign db_fimseq      = (limite == 4'hF);
  assign db_clock       = clock;
  assign db_iniciar     = jogar;
  assign db_tem_jogada  = tem_jogada;

endmodule

// File: tb/tb_circuito_exp6.sv
// tb/tb_circuito_exp6.sv - scoreboard bench for circuito_exp6
// Game outcomes are queued when a scenario is driven and checked once pronto rises.
module tb_circuito_exp6;

  logic       clock = 1'b0;
  logic       reset, jogar;
  logic [3:0] botoes;
  logic       ganhou, perdeu, pronto;
  logic [3:0] leds;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_sequencia;
  logic       db_igual, db_igualjogada, db_igualseq, db_fimseq;
  logic       db_clock, db_iniciar, db_tem_jogada, db_timeout;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [6:0] estado;
    logic       g;
    logic       p;
    logic       t;
    logic [3:0] leds;
  } exp_t;

  exp_t sb[$];
  int   rom [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};

  circuito_exp6 dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
    .db_jogadafeita(db_jogadafeita), .db_sequencia(db_sequencia),
    .db_igual(db_igual), .db_igualjogada(db_igualjogada), .db_igualseq(db_igualseq),
    .db_fimseq(db_fimseq), .db_clock(db_clock), .db_iniciar(db_iniciar),
    .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] hx(input int v);
    case (v)
      0: hx = 7'b1000000;   1: hx = 7'b1111001;   2: hx = 7'b0100100;   3: hx = 7'b0110000;
      4: hx = 7'b0011001;   5: hx = 7'b0010010;   6: hx = 7'b0000010;   7: hx = 7'b1111000;
      8: hx = 7'b0000000;   9: hx = 7'b0010000;  10: hx = 7'b0001000;  11: hx = 7'b0000011;
      12: hx = 7'b1000110; 13: hx = 7'b0100001;  14: hx = 7'b0000110;  15: hx = 7'b0001110;
      default: hx = 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] v, input int hold);
    @(negedge clock);
    botoes = v;
    repeat (hold) @(negedge clock);
    botoes = 4'b0000;
    repeat (10) @(negedge clock);
  endtask

  task automatic start_game();
    jogar = 1'b1;
    @(negedge clock);
    @(negedge clock);
    jogar = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int   n;
    exp_t e;
    n = 0;
    while (pronto !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_pronto"}, pronto, 1'b1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_estado"}, db_estado, e.estado);
      check({tag, "_ganhou"}, ganhou, e.g);
      check({tag, "_perdeu"}, perdeu, e.p);
      check({tag, "_timeout"}, db_timeout, e.t);
      check({tag, "_leds"}, leds, e.leds);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    jogar = 1'b0;
    botoes = 4'b0000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    check("rst_estado", db_estado, hx(0));
    check("rst_pronto", pronto, 1'b0);
    check("rst_ganhou", ganhou, 1'b0);
    check("rst_perdeu", perdeu, 1'b0);
    check("rst_leds", leds, 4'b0000);

    jogar = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("start_st%0d", i), db_estado, hx(i < 2 ? i + 1 : 3));
    end
    jogar = 1'b0;
    check("start_contagem", db_contagem, hx(0));
    check("start_sequencia", db_sequencia, hx(0));

    sb.push_back('{estado: hx(10), g: 1'b1, p: 1'b0, t: 1'b0, leds: 4'b0100});
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i <= r; i++) begin
        if (i == 0) check($sformatf("round%0d_seq", r), db_sequencia, hx(r));
        if (r == 1 && i == 0) begin
          check("hold_cnt_before", db_contagem, hx(0));
          press(4'(rom[0]), 30);
          check("hold_cnt_after", db_contagem, hx(1));
          check("hold_estado", db_estado, hx(3));
        end else begin
          press(4'(rom[i]), 10);
        end
      end
    end
    wait_done("win", 50);
    check("win_igual", db_igual, 1'b1);
    check("win_fimseq", db_fimseq, 1'b1);

    start_game();
    sb.push_back('{estado: hx(14), g: 1'b0, p: 1'b1, t: 1'b0, leds: 4'b0010});
    press(4'b0010, 10);
    wait_done("lose", 50);

    start_game();
    sb.push_back('{estado: hx(13), g: 1'b0, p: 1'b1, t: 1'b1, leds: 4'b0000});
    n = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clock);
      if (db_estado == hx(3)) n++;
      else if (n > 0) break;
    end
    check("timeout_cycles", n, 5000);
    wait_done("timeout", 20);

    start_game();
    press(4'(rom[0]), 10);
    check("mid_sequencia", db_sequencia, hx(1));
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_estado", db_estado, hx(0));
    check("async_sequencia", db_sequencia, hx(0));
    check("async_leds", leds, 4'b0000);
    check("async_pronto", pronto, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("post_rst_estado", db_estado, hx(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/circuito_exp6.md
CIRCUITO_EXP6 -- requirements
Module: circuito_exp6

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all ports below:
REQ-002 clock  in  1  system clock, 1 kHz nominal (1 ms period).
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 jogar  in  1  start/restart game, level-sensitive.
REQ-005 botoes  in  4  player buttons, one-hot when pressed, 0000 = none.
REQ-006 ganhou / perdeu  out  1 each  game won / game lost (wrong button or timeout).
REQ-007 pronto  out  1  game finished (won or lost).
REQ-008 leds  out  4  last registered play value.
REQ-009 db_contagem, db_memoria, db_estado, db_jogadafeita, db_sequencia  out  7 each  hex digits: play address, ROM data at that address, FSM state code, registered play, round limit.
REQ-010 db_igual, db_igualjogada  out  1  registered play == ROM data (same signal).
REQ-011 db_igualseq  out  1  play address == round limit; db_fimseq  out  1  round limit == 15.
REQ-012 db_clock  out  1  = clock; db_iniciar  out  1  = jogar; db_tem_jogada  out  1  = OR(botoes); db_timeout  out  1  timeout reached.

Function
REQ-013 7-segment digits: active-low, bit0=a…bit6=g; values 0-F (0 → 1000000).
REQ-014 ROM 16x4, fixed contents addr 0-15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (binary 0001,0010,0100,1000,…).
REQ-015 Play-address counter 4 bit (clear, enable); round-limit counter 4 bit (clear, enable).
REQ-016 Edge detector: jogada_feita = one-cycle pulse on rising edge of OR(botoes); holding a button SHALL produce exactly one pulse.
REQ-017 Play register 4 bit: cleared in preparacao, loads botoes in state registra.
REQ-018 Timeout counter: counts every cycle in espera_jogada, cleared on leaving it; timeout at 5000 cycles (5 s).
REQ-019 FSM states/codes: inicial 0, preparacao 1, inicia_rodada 2, espera_jogada 3, registra 4, comparacao 5, proxima_jogada 6, proxima_rodada 7, fim_ganhou A, fim_timeout D, fim_perdeu E.
REQ-020 inicial → preparacao when jogar=1; else stay.
REQ-021 preparacao (clear both counters, play register) → inicia_rodada.
REQ-022 inicia_rodada (clear address) → espera_jogada.
REQ-023 espera_jogada → registra on jogada_feita; → fim_timeout on timeout; jogada_feita wins if simultaneous.
REQ-024 registra → comparacao.
REQ-025 comparacao: mismatch → fim_perdeu; match & address<limit → proxima_jogada; match & address==limit & limit<15 → proxima_rodada; match & address==limit==15 → fim_ganhou.
REQ-026 proxima_jogada (address+1) → espera_jogada; proxima_rodada (limit+1) → inicia_rodada.
REQ-027 Terminal states hold; pronto=1 in all three; ganhou=1 in fim_ganhou; perdeu=1 in fim_perdeu and fim_timeout; jogar=1 → preparacao (new game).
REQ-028 Round r (limit r) requires plays of ROM[0..r]; 16 rounds, 136 correct plays to win.
REQ-029 ganhou, perdeu, pronto, db_timeout Moore outputs, 0 in all non-terminal states.

Reset
REQ-030 reset=1 SHALL immediately force inicial, counters/register/timeout/edge detector to 0, ganhou=perdeu=pronto=0, leds=0000, db_estado shows 0; reset mid-game aborts game.

Verification
REQ-031 Reset pulse, idle 15 cycles → db_estado "0", pronto=ganhou=perdeu=0, leds=0000.
REQ-032 jogar=1 for 5 cycles → states 1,2,3; waits in espera_jogada with db_contagem=0, db_sequencia=0.
REQ-033 Full correct game (round r: ROM[0..r], each press 10 cycles, 10-cycle gaps) → ganhou=1, pronto=1, db_estado "A", perdeu=0.
REQ-034 Round 0 press 0010 (expected 0001) → perdeu=1, pronto=1, db_estado "E", leds=0010.
REQ-035 After jogar, no press for 5000 cycles → db_timeout=1, perdeu=1, pronto=1, db_estado "D".
REQ-036 Button held 30 cycles in round 1 → only one play counted; db_contagem advances by 1.
